// File: rtl/seq_detector_param.sv
// Programmable Mealy serial-pattern detector with a run-time pattern, length and overlap mode.
// Optional saturating match counter is built when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h0A,
  parameter int                 DEF_LEN     = 4,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               x_valid,
  input  logic               x,
  output logic               match,
  output logic               match_r,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   ONE_W    = (LEN_W+1)'(1);

  // Bit i of the window takes part in the compare when i < len.
  function automatic logic [MAX_LEN:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN:0] m;
    m = '0;
    for (int i = 0; i <= MAX_LEN; i++)
      if (i < int'(len)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [LEN_W-1:0] fill_inc(input logic [LEN_W-1:0] f);
    return (f == MAX_FILL) ? f : f + LEN_W'(1);
  endfunction

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_p0;
  logic [LEN_W-1:0]   fill_p0;

  logic               cfg_ok;
  logic               fill_ok;
  logic               pat_eq;
  logic [MAX_LEN:0]   window;

  assign cfg_ok  = cfg_load && (cfg_len != '0) && (cfg_len <= MAX_FILL);
  assign window  = {hist_p0, x};
  assign fill_ok = ({1'b0, fill_p0} + ONE_W) >= {1'b0, len_q};
  assign pat_eq  = ((window ^ {1'b0, pattern_q}) & len_mask(len_q)) == '0;
  // An accepted load discards the bit of its own cycle, so it can never match.
  assign match   = x_valid && !cfg_ok && fill_ok && pat_eq;

  // ---- stage p0: configuration, history and fill level ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= 1'b1;
      hist_p0   <= '0;
      fill_p0   <= '0;
    end else if (cfg_ok) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      hist_p0   <= '0;
      fill_p0   <= '0;
    end else if (x_valid) begin
      hist_p0 <= window[MAX_LEN-1:0];
      fill_p0 <= (match && !overlap_q) ? '0 : fill_inc(fill_p0);
    end
  end

  // ---- stage p1: registered match and config-error pulse ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_r <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match_r <= match;
      cfg_err <= cfg_load && !cfg_ok;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= '0;
    else if (match && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: vector table plus hand-written reset and counter sequences.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cfg_err;
  logic       x_valid;
  logic       x;
  logic       match;
  logic       match_r;
  logic [1:0] match_cnt;
  logic       cnt_clr;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(
    .MAX_LEN(8), .LEN_W(4), .DEF_PATTERN(8'h0A), .DEF_LEN(4), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .x_valid(x_valid), .x(x), .match(match), .match_r(match_r),
    .match_cnt(match_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       v;
    logic       x;
    logic       em;
    logic       emr;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                              input logic ov, input logic v, input logic xb,
                              input logic em, input logic emr, input logic ee);
    vec_t r;
    r.ld = ld; r.pat = pat; r.len = len; r.ov = ov; r.v = v; r.x = xb;
    r.em = em; r.emr = emr; r.ee = ee;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic bit_in(input logic b, input logic clr);
    cfg_load = 1'b0;
    x_valid  = 1'b1;
    x        = b;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_cnt;
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    x_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;

    // ld  pat    len ov v  x  em emr ee
    // defaults "1010", overlapping
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    // non-overlapping "1010"; load-cycle bit discarded
    tbl.push_back(mk(1, 8'h0A, 4, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    // len=MAX_LEN pattern 10110101 with valid gaps
    tbl.push_back(mk(1, 8'hB5, 8, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    // rejected loads (len 0, len 9) keep "1010" and process x
    tbl.push_back(mk(1, 8'h0A, 4, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 9, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    // len=1, pattern bit 1
    tbl.push_back(mk(1, 8'h01, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));

    #12;
    chk("reset match", 32'(match), 32'd0);
    chk("reset match_r", 32'(match_r), 32'd0);
    chk("reset cfg_err", 32'(cfg_err), 32'd0);
    chk("reset match_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cfg_load = tbl[i].ld; cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len;
      cfg_overlap = tbl[i].ov; x_valid = tbl[i].v; x = tbl[i].x; cnt_clr = 1'b0;
      @(negedge clk);
      chk($sformatf("row%0d match", i), 32'(match), 32'(tbl[i].em));
      chk($sformatf("row%0d match_r", i), 32'(match_r), 32'(tbl[i].emr));
      chk($sformatf("row%0d cfg_err", i), 32'(cfg_err), 32'(tbl[i].ee));
      @(posedge clk);
      #1;
    end

    // async reset after 1,0,1 with the completing 0 already on x
    rst = 1'b0; #1; rst = 1'b1;
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    x = 1'b0;
    #1;
    chk("prereset match", 32'(match), 32'd1);
    rst = 1'b0;
    #1;
    chk("inreset match", 32'(match), 32'd0);
    chk("inreset match_r", 32'(match_r), 32'd0);
    chk("inreset cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
    chk("inreset edge match", 32'(match), 32'd0);
    chk("inreset edge match_r", 32'(match_r), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("postreset match", 32'(match), 32'd0);
    @(posedge clk);
    #1;
    chk("postreset match_r", 32'(match_r), 32'd0);

    // counter: fresh "1010" overlapping, 12 alternating bits -> 5 matches
    cfg_load = 1'b1; cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1;
    x_valid = 1'b0; cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      bit_in((i % 2) == 0, 1'b0);
`ifdef SEQDET_MATCH_CNT_EN
      exp_cnt = (i == 5) ? 2'd2 : 2'd3;
`else
      exp_cnt = 2'd0;
`endif
      if (i == 5 || i == 11) chk($sformatf("cnt after %0d bits", i + 1), 32'(match_cnt), 32'(exp_cnt));
    end
    bit_in(1'b1, 1'b0);
    x = 1'b0; cnt_clr = 1'b1;
    #1;
    chk("clr cycle match", 32'(match), 32'd1);
    @(posedge clk);
    #1;
    chk("cnt clr priority", 32'(match_cnt), 32'd0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
`ifdef SEQDET_MATCH_CNT_EN
    exp_cnt = 2'd1;
`else
    exp_cnt = 2'd0;
`endif
    chk("cnt after clr", 32'(match_cnt), 32'(exp_cnt));
    x_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
